// File: rtl/clock_time_setter_pkg.sv
// rtl/clock_time_setter_pkg.sv - shared states, targets and BCD limits for the clock time setter
package clock_setter_pkg;

   typedef enum logic [1:0] {IDLE, EDIT_HR, EDIT_MIN, COMMIT} state_e;
   typedef enum logic {TIME, ALARM} tgt_e;

   localparam logic [1:0] HR_MAX_TENS       = 2'd2;
   localparam logic [3:0] HR_MAX_UNITS_AT_2 = 4'd3;
   localparam logic [3:0] MIN_MAX_TENS      = 4'd5;

   typedef struct packed {
      logic [1:0] h1;
      logic [3:0] h0;
      logic [3:0] m1;
      logic [3:0] m0;
   } bcd_time_t;

endpackage

// File: rtl/clock_time_setter_if.sv
// rtl/clock_time_setter_if.sv - load bus between the setter (master) and the alarm clock (slave)
interface clock_time_setter_if;

   logic [1:0] H_in1;
   logic [3:0] H_in0;
   logic [3:0] M_in1;
   logic [3:0] M_in0;
   logic       LD_time;
   logic       LD_alarm;
   logic [1:0] cur_H1;
   logic [3:0] cur_H0;
   logic [3:0] cur_M1;
   logic [3:0] cur_M0;

   modport master (
      output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm,
      input  cur_H1, cur_H0, cur_M1, cur_M0
   );

   modport slave (
      input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm,
      output cur_H1, cur_H0, cur_M1, cur_M0
   );

endinterface

// File: rtl/clock_time_setter_btn_sync_edge.sv
// rtl/clock_time_setter_btn_sync_edge.sv - two-flop synchroniser plus one-cycle rising-edge pulse
module btn_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= btn_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/clock_time_setter.sv
// rtl/clock_time_setter.sv - pushbutton editor that loads time or alarm into the alarm clock
module clock_time_setter
   import clock_setter_pkg::*;
#(
   parameter int LD_HOLD = 10,
   parameter int TIMEOUT = 300
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       btn_time,
   input  logic                       btn_alarm,
   input  logic                       btn_inc,
   input  logic                       btn_next,
   clock_time_setter_if.master        bus,
   output logic                       editing,
   output logic                       field
);

   // One counter serves both the edit timeout and the commit hold window.
   localparam int CW = $clog2((TIMEOUT > LD_HOLD) ? TIMEOUT : LD_HOLD) + 1;
   localparam logic [CW-1:0] TO_RELOAD   = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] HOLD_RELOAD = CW'(LD_HOLD - 1);

   function automatic bcd_time_t hr_inc(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.h1 == HR_MAX_TENS && t.h0 == HR_MAX_UNITS_AT_2) begin
         r.h1 = 2'd0;
         r.h0 = 4'd0;
      end else if (t.h0 == 4'd9) begin
         r.h1 = t.h1 + 2'd1;
         r.h0 = 4'd0;
      end else begin
         r.h0 = t.h0 + 4'd1;
      end
      return r;
   endfunction

   // Minute rollover deliberately leaves the hour untouched.
   function automatic bcd_time_t min_inc(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.m1 == MIN_MAX_TENS && t.m0 == 4'd9) begin
         r.m1 = 4'd0;
         r.m0 = 4'd0;
      end else if (t.m0 == 4'd9) begin
         r.m1 = t.m1 + 4'd1;
         r.m0 = 4'd0;
      end else begin
         r.m0 = t.m0 + 4'd1;
      end
      return r;
   endfunction

   logic time_p, alarm_p, inc_p, next_p;

   btn_sync_edge u_sync_time  (.clk(clk), .reset(reset), .btn_i(btn_time),  .pulse_o(time_p));
   btn_sync_edge u_sync_alarm (.clk(clk), .reset(reset), .btn_i(btn_alarm), .pulse_o(alarm_p));
   btn_sync_edge u_sync_inc   (.clk(clk), .reset(reset), .btn_i(btn_inc),   .pulse_o(inc_p));
   btn_sync_edge u_sync_next  (.clk(clk), .reset(reset), .btn_i(btn_next),  .pulse_o(next_p));

   state_e          state_q;
   tgt_e            tgt_q;
   bcd_time_t       edit_q;
   bcd_time_t       shadow_q;
   bcd_time_t       inc_d;
   logic [CW-1:0]   cnt_q;
   logic            ld_time_q, ld_alarm_q, editing_q, field_q;

   assign inc_d = (state_q == EDIT_HR) ? hr_inc(edit_q) : min_inc(edit_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         tgt_q      <= TIME;
         edit_q     <= '0;
         shadow_q   <= '0;
         cnt_q      <= '0;
         ld_time_q  <= 1'b0;
         ld_alarm_q <= 1'b0;
         editing_q  <= 1'b0;
         field_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (time_p) begin
                  edit_q    <= {bus.cur_H1, bus.cur_H0, bus.cur_M1, bus.cur_M0};
                  tgt_q     <= TIME;
                  state_q   <= EDIT_HR;
                  cnt_q     <= TO_RELOAD;
                  editing_q <= 1'b1;
                  field_q   <= 1'b0;
               end else if (alarm_p) begin
                  edit_q    <= shadow_q;
                  tgt_q     <= ALARM;
                  state_q   <= EDIT_HR;
                  cnt_q     <= TO_RELOAD;
                  editing_q <= 1'b1;
                  field_q   <= 1'b0;
               end
            end
            EDIT_HR, EDIT_MIN: begin
               if (next_p) begin
                  if (state_q == EDIT_HR) begin
                     state_q <= EDIT_MIN;
                     field_q <= 1'b1;
                     cnt_q   <= TO_RELOAD;
                  end else begin
                     state_q    <= COMMIT;
                     cnt_q      <= HOLD_RELOAD;
                     editing_q  <= 1'b0;
                     field_q    <= 1'b0;
                     ld_time_q  <= (tgt_q == TIME);
                     ld_alarm_q <= (tgt_q == ALARM);
                     if (tgt_q == ALARM) shadow_q <= edit_q;
                  end
               end else if (inc_p) begin
                  edit_q <= inc_d;
                  cnt_q  <= TO_RELOAD;
               end else if (cnt_q == '0) begin
                  state_q   <= IDLE;
                  editing_q <= 1'b0;
                  field_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            COMMIT: begin
               if (cnt_q == '0) begin
                  state_q    <= IDLE;
                  ld_time_q  <= 1'b0;
                  ld_alarm_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.H_in1    = edit_q.h1;
   assign bus.H_in0    = edit_q.h0;
   assign bus.M_in1    = edit_q.m1;
   assign bus.M_in0    = edit_q.m0;
   assign bus.LD_time  = ld_time_q;
   assign bus.LD_alarm = ld_alarm_q;
   assign editing      = editing_q;
   assign field        = field_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// tb/tb_clock_time_setter.sv - scoreboard bench for the clock time setter
module tb_clock_time_setter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn_time = 1'b0, btn_alarm = 1'b0, btn_inc = 1'b0, btn_next = 1'b0;
   logic editing, field;

   clock_time_setter_if bus ();

   clock_time_setter #(.LD_HOLD(10), .TIMEOUT(300)) dut (
      .clk(clk), .reset(reset),
      .btn_time(btn_time), .btn_alarm(btn_alarm), .btn_inc(btn_inc), .btn_next(btn_next),
      .bus(bus.master), .editing(editing), .field(field)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain hours/minutes integers, converted to BCD only for comparison.
   int m_h = 0, m_m = 0, sh_h = 0, sh_m = 0;
   bit m_alarm = 0, m_edit = 0, m_field = 0;

   function automatic logic [13:0] to_bcd(input int h, input int m);
      return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   logic [13:0] dut_val;
   assign dut_val = {bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0};

   typedef struct {
      bit          is_alarm;
      logic [13:0] val;
      int          start;
      int          len;
   } exp_t;
   exp_t sbq[$];

   // Drives a button set; a positive len means this press commits and a strobe is expected.
   task automatic press_begin(input bit t, input bit a, input bit i, input bit n, input int len);
      exp_t e;
      @(negedge clk);
      btn_time = t; btn_alarm = a; btn_inc = i; btn_next = n;
      if (len > 0) begin
         e.is_alarm = m_alarm;
         e.val      = to_bcd(m_h, m_m);
         e.start    = cyc + 3;
         e.len      = len;
         sbq.push_back(e);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic press_end();
      btn_time = 0; btn_alarm = 0; btn_inc = 0; btn_next = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_val"}, 32'(dut_val), 32'(to_bcd(m_h, m_m)));
      chk({tag, "_editing"}, 32'(editing), 32'(m_edit));
      if (m_edit) chk({tag, "_field"}, 32'(field), 32'(m_field));
   endtask

   task automatic act_time(input int h, input int m);
      logic [13:0] b;
      b = to_bcd(h, m);
      bus.cur_H1 = b[13:12]; bus.cur_H0 = b[11:8]; bus.cur_M1 = b[7:4]; bus.cur_M0 = b[3:0];
      press_begin(1, 0, 0, 0, 0);
      m_h = h; m_m = m; m_alarm = 0; m_edit = 1; m_field = 0;
      check_state("time_preload");
      press_end();
   endtask

   task automatic act_alarm();
      press_begin(0, 1, 0, 0, 0);
      m_h = sh_h; m_m = sh_m; m_alarm = 1; m_edit = 1; m_field = 0;
      check_state("alarm_preload");
      press_end();
   endtask

   task automatic act_inc();
      press_begin(0, 0, 1, 0, 0);
      if (!m_field) m_h = (m_h + 1) % 24;
      else          m_m = (m_m + 1) % 60;
      check_state(m_field ? "min_inc" : "hr_inc");
      press_end();
   endtask

   task automatic act_next_hr();
      press_begin(0, 0, 0, 1, 0);
      m_field = 1;
      check_state("next_hr");
      press_end();
   endtask

   task automatic act_commit();
      press_begin(0, 0, 0, 1, 10);
      if (m_alarm) begin sh_h = m_h; sh_m = m_m; end
      m_edit = 0; m_field = 0;
      check_state("commit");
      press_end();
      repeat (10) @(negedge clk);
   endtask

   // Monitor: pops an expectation at each strobe rise and measures the strobe on its fall.
   bit          in_str = 0;
   bit          s_bad;
   int          s_len;
   logic [13:0] s_val;
   exp_t        cur_e;
   logic        ldt, lda;

   always @(negedge clk) begin
      ldt = bus.LD_time;
      lda = bus.LD_alarm;
      if (!in_str && (ldt === 1'b1 || lda === 1'b1)) begin
         if (sbq.size() == 0) begin
            chk("unexpected_strobe", 32'({ldt, lda}), 32'd0);
            cur_e.len = -1;
         end else begin
            cur_e = sbq.pop_front();
            chk("strobe_tgt", 32'({ldt, lda}), cur_e.is_alarm ? 32'd1 : 32'd2);
            chk("strobe_val", 32'(dut_val), 32'(cur_e.val));
            chk("strobe_start", 32'(cyc), 32'(cur_e.start));
         end
         in_str = 1; s_len = 1; s_val = dut_val; s_bad = 0;
      end else if (in_str && (ldt === 1'b1 || lda === 1'b1)) begin
         s_len++;
         if (dut_val !== s_val || (ldt && lda)) s_bad = 1;
      end else if (in_str) begin
         in_str = 0;
         chk("strobe_len", 32'(s_len), 32'(cur_e.len));
         chk("strobe_stable", 32'(s_bad), 32'd0);
      end
   end

   initial begin
      bus.cur_H1 = 0; bus.cur_H0 = 0; bus.cur_M1 = 0; bus.cur_M0 = 0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 0;
      chk("rst_val", 32'(dut_val), 32'd0);
      chk("rst_ld", 32'({bus.LD_time, bus.LD_alarm}), 32'd0);
      chk("rst_editing", 32'(editing), 32'd0);
      chk("rst_field", 32'(field), 32'd0);
      repeat (100) @(negedge clk);
      chk("idle_editing", 32'(editing), 32'd0);

      // Time edit 10:26 -> 13:30
      act_time(10, 26);
      repeat (3) act_inc();
      act_next_hr();
      repeat (4) act_inc();
      act_commit();

      // Hour wrap through 09->10, 19->20, 23->00 then minute wrap 58->00
      act_alarm();
      repeat (24) act_inc();
      act_next_hr();
      repeat (58) act_inc();
      repeat (2) act_inc();
      act_commit();

      // Alarm shadow 11:35 preloads on the next alarm edit
      act_alarm();
      repeat (11) act_inc();
      act_next_hr();
      repeat (35) act_inc();
      act_commit();
      act_alarm();
      act_next_hr();
      act_commit();

      // Timeout with no strobe, edit values retained
      bus.cur_H1 = 2'd1; bus.cur_H0 = 4'd8; bus.cur_M1 = 4'd4; bus.cur_M0 = 4'd7;
      press_begin(1, 0, 0, 0, 0);
      m_h = 18; m_m = 47; m_alarm = 0; m_edit = 1; m_field = 0;
      check_state("to_preload");
      repeat (299) @(negedge clk);
      chk("to_still_editing", 32'(editing), 32'd1);
      @(negedge clk);
      m_edit = 0;
      check_state("timeout");
      press_end();

      // Next wins over inc in the hour field
      act_time(21, 5);
      press_begin(0, 0, 1, 1, 0);
      m_field = 1;
      check_state("prio");
      press_end();
      act_inc();
      act_commit();

      // Randomised edits against the model
      for (int r = 0; r < 6; r++) begin
         if ($urandom_range(0, 1) == 1) act_alarm();
         else act_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
         for (int k = $urandom_range(0, 14); k > 0; k--) act_inc();
         act_next_hr();
         for (int k = $urandom_range(0, 14); k > 0; k--) act_inc();
         act_commit();
      end

      // Reset during the fourth strobe cycle
      act_alarm();
      act_inc();
      act_next_hr();
      act_inc();
      press_begin(0, 0, 0, 1, 4);
      repeat (3) @(negedge clk);
      reset = 1;
      @(negedge clk);
      chk("midrst_ld", 32'({bus.LD_time, bus.LD_alarm}), 32'd0);
      chk("midrst_val", 32'(dut_val), 32'd0);
      btn_next = 0;
      @(negedge clk);
      reset = 0;
      m_h = 0; m_m = 0; sh_h = 0; sh_m = 0; m_edit = 0; m_field = 0;
      repeat (3) @(negedge clk);
      act_alarm();
      act_next_hr();
      act_commit();

      repeat (20) @(negedge clk);
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      chk("strobe_idle", 32'(in_str), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
